// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/stall controller.
//   state_e      : controller FSM states (RUN / WAIT / HALT)
//   REG_W        : register-index width
//   WB_MEM       : writeback-select code for a load (data comes from memory)
//   FWD_*        : ALU operand-source codes driven on fwd_a / fwd_b
//   cnt_next     : saturating performance-counter next-value helper
package pipe_ctrl_pkg;

    localparam int REG_W = 5;

    localparam logic [1:0] WB_MEM  = 2'b01;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_RUN  = 2'b00,
        ST_WAIT = 2'b01,
        ST_HALT = 2'b10
    } state_e;

    // Clear wins over increment; the count sticks at all-ones.
    function automatic logic [31:0] cnt_next(input logic [31:0] cur,
                                             input logic        clr,
                                             input logic        inc);
        logic [31:0] nxt;
        nxt = cur;
        if (clr) begin
            nxt = '0;
        end else if (inc && (cur != CNT_MAX)) begin
            nxt = cur + 32'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/pipe_ctrl_fwd_unit.sv
// Operand forwarding select for both EX-stage ALU operands.
//   ex_rs1, ex_rs2        : source registers of the instruction in EX
//   mem_rd, mem_regwen    : destination / write-enable in MEM
//   wb_rd, wb_regwen      : destination / write-enable in WB
//   fwd_a, fwd_b          : FWD_MEM, FWD_WB or FWD_REG per operand
module fwd_unit
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] ex_rs1,
    input  logic [REG_W-1:0] ex_rs2,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             mem_regwen,
    input  logic [REG_W-1:0] wb_rd,
    input  logic             wb_regwen,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b
);

    // MEM holds the younger result, so it is checked first. x0 never forwards.
    function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] rs,
                                           input logic [REG_W-1:0] m_rd,
                                           input logic             m_wen,
                                           input logic [REG_W-1:0] w_rd,
                                           input logic             w_wen);
        logic [1:0] sel;
        sel = FWD_REG;
        if (m_wen && (m_rd != '0) && (m_rd == rs)) begin
            sel = FWD_MEM;
        end else if (w_wen && (w_rd != '0) && (w_rd == rs)) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

    always_comb begin
        fwd_a = fwd_sel(ex_rs1, mem_rd, mem_regwen, wb_rd, wb_regwen);
        fwd_b = fwd_sel(ex_rs2, mem_rd, mem_regwen, wb_rd, wb_regwen);
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: memory-wait freeze with timeout, load-use stall,
// taken-branch flush, operand forwarding and stall/flush performance counters.
//   clk, rst (async, active-low)
//   id_*/ex_*/mem_*/wb_*  : per-stage register indices and write controls
//   br_taken              : EX resolved a taken branch/jump
//   dmem_req, dmem_ready  : MEM-stage access handshake
//   cnt_clr               : synchronous clear of stall_cnt / flush_cnt
//   *_en, *_flush         : stage-register enables and bubble inserts
//   fwd_a, fwd_b          : ALU operand sources
//   halted                : sticky memory-timeout flag (cleared only by rst)
//   stall_cnt, flush_cnt  : saturating performance counters
//
// state | meaning
// RUN   | normal flow, hazards resolved combinationally
// WAIT  | data memory not ready, pipeline frozen, wait_cnt running
// HALT  | memory timeout, everything frozen until reset
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [REG_W-1:0] ex_rs1,
    input  logic [REG_W-1:0] ex_rs2,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_regwen,
    input  logic [1:0]       ex_wbsel,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             mem_regwen,
    input  logic [REG_W-1:0] wb_rd,
    input  logic             wb_regwen,
    input  logic             br_taken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    input  logic             cnt_clr,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             halted,
    output logic [31:0]      stall_cnt,
    output logic [31:0]      flush_cnt
);

    localparam logic [15:0] TIMEOUT_CNT = TIMEOUT[15:0];

    state_e      state_q, state_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    logic        freeze;
    logic        load_use;
    logic        stall_ev;
    logic        flush_ev;
    logic [1:0]  fwd_a_raw, fwd_b_raw;

    assign freeze   = dmem_req & ~dmem_ready;
    assign load_use = ex_regwen && (ex_wbsel == WB_MEM) && (ex_rd != '0) &&
                      ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                       (id_use_rs2 && (id_rs2 == ex_rd)));

    fwd_unit u_fwd (
        .ex_rs1     (ex_rs1),
        .ex_rs2     (ex_rs2),
        .mem_rd     (mem_rd),
        .mem_regwen (mem_regwen),
        .wb_rd      (wb_rd),
        .wb_regwen  (wb_regwen),
        .fwd_a      (fwd_a_raw),
        .fwd_b      (fwd_b_raw)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_RUN;
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Next state, wait counter and performance counters.
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;

        if (state_q != ST_HALT) begin
            if (freeze) begin
                wait_cnt_d = (wait_cnt_q == 16'hFFFF) ? wait_cnt_q : wait_cnt_q + 16'd1;
            end else begin
                wait_cnt_d = '0;
            end
            stall_cnt_d = cnt_next(stall_cnt_q, cnt_clr, stall_ev);
            flush_cnt_d = cnt_next(flush_cnt_q, cnt_clr, flush_ev);
        end

        case (state_q)
            ST_RUN: begin
                if (freeze) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!freeze) begin
                    state_d = ST_RUN;
                end else if (wait_cnt_d >= TIMEOUT_CNT) begin
                    state_d = ST_HALT;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Output decode. Everything is forced idle while rst is asserted so the
    // pipeline cannot advance during reset.
    always_comb begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_en    = 1'b0;
        ex_mem_en   = 1'b0;
        mem_wb_en   = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        flush_ev    = 1'b0;

        if (rst && (state_q != ST_HALT) && !freeze) begin
            pc_en     = 1'b1;
            if_id_en  = 1'b1;
            id_ex_en  = 1'b1;
            ex_mem_en = 1'b1;
            mem_wb_en = 1'b1;
            // A taken branch squashes the dependent instruction anyway,
            // so it takes precedence over the load-use stall.
            if (br_taken) begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
                flush_ev    = 1'b1;
            end else if (load_use) begin
                pc_en       = 1'b0;
                if_id_en    = 1'b0;
                id_ex_flush = 1'b1;
            end
        end

        stall_ev  = (state_q != ST_HALT) && !pc_en;
        halted    = (state_q == ST_HALT);
        fwd_a     = rst ? fwd_a_raw : FWD_REG;
        fwd_b     = rst ? fwd_b_raw : FWD_REG;
        stall_cnt = stall_cnt_q;
        flush_cnt = flush_cnt_q;
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

    localparam int TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic        id_use_rs1, id_use_rs2, ex_regwen, mem_regwen, wb_regwen;
    logic [1:0]  ex_wbsel;
    logic        br_taken, dmem_req, dmem_ready, cnt_clr;
    logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic        if_id_flush, id_ex_flush, halted;
    logic [1:0]  fwd_a, fwd_b;
    logic [31:0] stall_cnt, flush_cnt;

    int n_chk = 0;
    int n_err = 0;

    // reference model state
    logic        m_halt;
    int          m_run;
    logic [31:0] m_stall, m_flush;
    logic        e_pc, e_ifid, e_idex, e_exmem, e_memwb, e_fl1, e_fl2;
    logic [1:0]  e_fa, e_fb;
    logic        e_stall_inc, e_flush_inc;

    always #5 clk = ~clk;

    pipe_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_regwen(ex_regwen), .ex_wbsel(ex_wbsel),
        .mem_rd(mem_rd), .mem_regwen(mem_regwen), .wb_rd(wb_rd), .wb_regwen(wb_regwen),
        .br_taken(br_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready), .cnt_clr(cnt_clr),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
        .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] fwd_ref(input logic [4:0] rs);
        if (mem_regwen && mem_rd != 0 && mem_rd == rs) return 2'b10;
        if (wb_regwen && wb_rd != 0 && wb_rd == rs) return 2'b01;
        return 2'b00;
    endfunction

    // Expected outputs from the behavioural rules for the current inputs.
    task automatic model_eval();
        logic frz, lu;
        frz = dmem_req && !dmem_ready;
        lu  = ex_regwen && ex_wbsel == 2'b01 && ex_rd != 0 &&
              ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
        {e_pc, e_ifid, e_idex, e_exmem, e_memwb, e_fl1, e_fl2} = '0;
        if (!m_halt && !frz) begin
            {e_pc, e_ifid, e_idex, e_exmem, e_memwb} = '1;
            if (br_taken) begin
                e_fl1 = 1; e_fl2 = 1;
            end else if (lu) begin
                e_pc = 0; e_ifid = 0; e_fl2 = 1;
            end
        end
        e_stall_inc = !m_halt && !e_pc;
        e_flush_inc = !m_halt && !frz && br_taken;
        e_fa = fwd_ref(ex_rs1);
        e_fb = fwd_ref(ex_rs2);
    endtask

    function automatic logic [31:0] sat_ref(input logic [31:0] v, input logic inc);
        if (cnt_clr) return 0;
        if (inc && v != 32'hFFFF_FFFF) return v + 1;
        return v;
    endfunction

    task automatic model_update();
        if (!m_halt) begin
            m_stall = sat_ref(m_stall, e_stall_inc);
            m_flush = sat_ref(m_flush, e_flush_inc);
            if (dmem_req && !dmem_ready) begin
                m_run++;
                // first frozen cycle only enters WAIT; halt once TIMEOUT consecutive
                if (m_run >= TIMEOUT && m_run >= 2) m_halt = 1;
            end else begin
                m_run = 0;
            end
        end
    endtask

    task automatic check_all();
        chk1("pc_en", pc_en, e_pc);
        chk1("if_id_en", if_id_en, e_ifid);
        chk1("id_ex_en", id_ex_en, e_idex);
        chk1("ex_mem_en", ex_mem_en, e_exmem);
        chk1("mem_wb_en", mem_wb_en, e_memwb);
        chk1("if_id_flush", if_id_flush, e_fl1);
        chk1("id_ex_flush", id_ex_flush, e_fl2);
        chk2("fwd_a", fwd_a, e_fa);
        chk2("fwd_b", fwd_b, e_fb);
        chk1("halted", halted, m_halt);
        chk32("stall_cnt", stall_cnt, m_stall);
        chk32("flush_cnt", flush_cnt, m_flush);
    endtask

    task automatic tick();
        #1;
        model_eval();
        check_all();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle();
        {id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd} = '0;
        {id_use_rs1, id_use_rs2, ex_regwen, mem_regwen, wb_regwen} = '0;
        ex_wbsel = 2'b00;
        {br_taken, dmem_req, dmem_ready, cnt_clr} = '0;
    endtask

    task automatic do_reset();
        rst = 0;
        #1;
        chk1("rst_pc_en", pc_en, 1'b0);
        chk1("rst_mem_wb_en", mem_wb_en, 1'b0);
        chk1("rst_halted", halted, 1'b0);
        chk32("rst_stall_cnt", stall_cnt, 32'd0);
        chk32("rst_flush_cnt", flush_cnt, 32'd0);
        m_halt = 0; m_run = 0; m_stall = 0; m_flush = 0;
        @(posedge clk);
        @(negedge clk);
        rst = 1;
    endtask

    task automatic set_load_use();
        ex_wbsel = 2'b01; ex_rd = 5; ex_regwen = 1; id_rs1 = 5; id_use_rs1 = 1;
    endtask

    initial begin
        idle();
        dmem_req = 1; dmem_ready = 0; br_taken = 1; mem_regwen = 1; mem_rd = 3; ex_rs1 = 3;
        @(negedge clk);
        #1;
        chk1("rst_if_id_flush", if_id_flush, 1'b0);
        chk2("rst_fwd_a", fwd_a, 2'b00);
        idle();
        do_reset();

        // load-use stall
        set_load_use();
        #1;
        chk1("lu_pc_en", pc_en, 1'b0);
        chk1("lu_if_id_en", if_id_en, 1'b0);
        chk1("lu_id_ex_flush", id_ex_flush, 1'b1);
        chk1("lu_id_ex_en", id_ex_en, 1'b1);
        tick();
        chk32("lu_stall_cnt", stall_cnt, 32'd1);
        idle(); tick();

        // branch overrides load-use
        set_load_use(); br_taken = 1;
        #1;
        chk1("br_if_id_flush", if_id_flush, 1'b1);
        chk1("br_id_ex_flush", id_ex_flush, 1'b1);
        chk1("br_pc_en", pc_en, 1'b1);
        tick();
        chk32("br_flush_cnt", flush_cnt, 32'd1);
        chk32("br_stall_cnt", stall_cnt, 32'd1);
        idle();

        // memory wait with a pending branch
        dmem_req = 1; dmem_ready = 0; br_taken = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk1("frz_pc_en", pc_en, 1'b0);
            chk1("frz_if_id_flush", if_id_flush, 1'b0);
            tick();
        end
        dmem_ready = 1;
        #1;
        chk1("rdy_if_id_flush", if_id_flush, 1'b1);
        chk1("rdy_pc_en", pc_en, 1'b1);
        tick();
        chk32("frz_flush_cnt", flush_cnt, 32'd2);
        chk32("frz_stall_cnt", stall_cnt, 32'd4);
        idle();

        // wait counter clears between freezes: no timeout
        repeat (2) begin
            dmem_req = 1; dmem_ready = 0;
            repeat (3) tick();
            dmem_ready = 1; tick();
        end
        chk1("no_timeout_halted", halted, 1'b0);
        idle();

        // forwarding priority and x0
        mem_rd = 7; wb_rd = 7; ex_rs1 = 7; mem_regwen = 1; wb_regwen = 1;
        #1; chk2("fwd_tie", fwd_a, 2'b10); tick();
        mem_rd = 0; wb_rd = 0;
        #1; chk2("fwd_x0", fwd_a, 2'b00); tick();
        wb_rd = 9; ex_rs2 = 9;
        #1; chk2("fwd_wb_b", fwd_b, 2'b01); tick();
        idle();

        // memory timeout
        dmem_req = 1; dmem_ready = 0;
        repeat (TIMEOUT) tick();
        chk1("to_halted", halted, 1'b1);
        dmem_ready = 1; br_taken = 1; set_load_use();
        #1;
        chk1("halt_pc_en", pc_en, 1'b0);
        chk1("halt_if_id_flush", if_id_flush, 1'b0);
        repeat (3) tick();
        idle();
        do_reset();
        #1;
        chk1("post_rst_halted", halted, 1'b0);
        chk32("post_rst_stall", stall_cnt, 32'd0);
        set_load_use(); tick();
        chk32("post_rst_first_edge", stall_cnt, 32'd1);
        idle();

        // saturation and clear priority
        force dut.stall_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cnt_q;
        m_stall = 32'hFFFF_FFFE;
        set_load_use();
        repeat (3) tick();
        chk32("sat_stall_cnt", stall_cnt, 32'hFFFF_FFFF);
        cnt_clr = 1; tick();
        chk32("clr_stall_cnt", stall_cnt, 32'd0);
        idle();

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
            ex_rs1 = 5'($urandom_range(0, 3)); ex_rs2 = 5'($urandom_range(0, 3));
            ex_rd  = 5'($urandom_range(0, 3)); mem_rd = 5'($urandom_range(0, 3));
            wb_rd  = 5'($urandom_range(0, 3));
            id_use_rs1 = 1'($urandom_range(0, 1)); id_use_rs2 = 1'($urandom_range(0, 1));
            ex_regwen  = 1'($urandom_range(0, 1)); mem_regwen = 1'($urandom_range(0, 1));
            wb_regwen  = 1'($urandom_range(0, 1));
            ex_wbsel   = 2'($urandom_range(0, 3));
            br_taken   = ($urandom_range(0, 3) == 0);
            dmem_req   = ($urandom_range(0, 2) == 0);
            dmem_ready = ($urandom_range(0, 4) < 2);
            cnt_clr    = ($urandom_range(0, 40) == 0);
            tick();
            if (m_halt && $urandom_range(0, 3) == 0) begin
                idle();
                do_reset();
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
